// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based issue/stall/flush controller for the vector ASIP decode stage.
// Tracks pending writebacks to 16 scalar + 16 vector registers and sequences jump flushes.
module pipe_hazard_ctrl #(
  parameter int unsigned ALU_LAT      = 3,
  parameter int unsigned MEM_LAT      = 5,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [1:0]  id_op,
  input  logic [1:0]  id_inst,
  input  logic        id_flagV,
  input  logic [3:0]  id_r1,
  input  logic [3:0]  id_r2,
  input  logic [3:0]  id_r3,
  input  logic        ex_jmp,
  output logic        issue,
  output logic        stall,
  output logic        pc_en,
  output logic        fetch_flush,
  output logic [15:0] stall_cnt
);

  localparam logic [2:0] AluLat    = 3'(ALU_LAT);
  localparam logic [2:0] MemLat    = 3'(MEM_LAT);
  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [2:0]  sb_q [32];
  logic [2:0]  sb_d [32];
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic       rd_a_en, rd_b_en, wr_en;
  logic [3:0] rd_a, rd_b;
  logic [2:0] wr_lat;
  logic       hazard, flushing;

  // Register-use decode of the instruction in decode.
  always_comb begin
    rd_a_en = 1'b0;
    rd_b_en = 1'b0;
    wr_en   = 1'b0;
    rd_a    = id_r2;
    rd_b    = id_r3;
    wr_lat  = AluLat;
    unique case (id_op)
      2'b00: begin
        wr_en   = 1'b1;
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
      end
      2'b01: begin
        if (id_inst == 2'b00) begin
          wr_en   = 1'b1;
          wr_lat  = MemLat;
          rd_a_en = 1'b1;
        end else if (id_inst == 2'b01) begin
          rd_a    = id_r1;
          rd_b    = id_r2;
          rd_a_en = 1'b1;
          rd_b_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    hazard = id_valid & (
             (rd_a_en & (sb_q[{id_flagV, rd_a}] != 3'd0)) |
             (rd_b_en & (sb_q[{id_flagV, rd_b}] != 3'd0)) |
             (wr_en   & (sb_q[{id_flagV, id_r1}] != 3'd0)));
    flushing    = ex_jmp | (state_q == StFlush);
    fetch_flush = rst | flushing;
    stall       = ~rst & hazard & ~flushing;
    issue       = ~rst & id_valid & ~hazard & ~flushing;
    pc_en       = ~rst & ~stall;
    stall_cnt   = stall_cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < 32; i++) begin
      sb_d[i] = (sb_q[i] != 3'd0) ? sb_q[i] - 3'd1 : 3'd0;
    end
    if (issue && wr_en) sb_d[{id_flagV, id_r1}] = wr_lat;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;

    unique case (state_q)
      StRun: begin
        if (ex_jmp) begin
          state_d     = StFlush;
          flush_cnt_d = FlushLoad;
        end
      end
      StFlush: begin
        if (ex_jmp) begin
          flush_cnt_d = FlushLoad;
        end else if (flush_cnt_q == 3'd0) begin
          state_d = StRun;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      flush_cnt_q <= 3'd0;
      stall_cnt_q <= 16'd0;
      for (int i = 0; i < 32; i++) sb_q[i] <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < 32; i++) sb_q[i] <= sb_d[i];
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with default latencies (3/5/2).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_flagV, ex_jmp;
  logic [1:0]  id_op, id_inst;
  logic [3:0]  id_r1, id_r2, id_r3;
  logic        issue, stall, pc_en, fetch_flush;
  logic [15:0] stall_cnt;

  int n_total = 0;
  int n_pass  = 0;

  pipe_hazard_ctrl #(.ALU_LAT(3), .MEM_LAT(5), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_inst(id_inst),
    .id_flagV(id_flagV), .id_r1(id_r1), .id_r2(id_r2), .id_r3(id_r3), .ex_jmp(ex_jmp),
    .issue(issue), .stall(stall), .pc_en(pc_en), .fetch_flush(fetch_flush),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic v, input logic [1:0] op, input logic [1:0] inst,
                          input logic fv, input logic [3:0] r1, input logic [3:0] r2,
                          input logic [3:0] r3);
    id_valid = v; id_op = op; id_inst = inst; id_flagV = fv;
    id_r1 = r1; id_r2 = r2; id_r3 = r3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ex_jmp = 1'b0;
    set_inst(1'b0, 2'b00, 2'b00, 1'b0, 4'd0, 4'd0, 4'd0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_jmp = 1'b0;
    set_inst(1'b1, 2'b00, 2'b00, 1'b0, 4'd1, 4'd2, 4'd3);
    #1;
    n_total++;
    if ({issue, stall, pc_en, fetch_flush} !== 4'b0001)
      $display("FAIL reset_outputs: got %b want 0001", {issue, stall, pc_en, fetch_flush});
    else n_pass++;
    n_total++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %h want 0000", stall_cnt);
    else n_pass++;
    cyc();
    rst = 1'b0;
    #1;
    n_total++;
    if ({issue, stall, pc_en, fetch_flush} !== 4'b1010)
      $display("FAIL post_reset_issue: got %b want 1010", {issue, stall, pc_en, fetch_flush});
    else n_pass++;
  endtask

  task automatic test_raw();
    do_reset();
    set_inst(1'b1, 2'b00, 2'b00, 1'b0, 4'd3, 4'd0, 4'd0);
    #1;
    n_total++;
    if (issue !== 1'b1) $display("FAIL raw_producer_issue: got %b want 1", issue);
    else n_pass++;
    cyc();
    set_inst(1'b1, 2'b00, 2'b00, 1'b0, 4'd4, 4'd3, 4'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if ({issue, stall, pc_en} !== 3'b010)
        $display("FAIL raw_stall_c%0d: got %b want 010", i, {issue, stall, pc_en});
      else n_pass++;
      cyc();
    end
    #1;
    n_total++;
    if ({issue, stall} !== 2'b10) $display("FAIL raw_dep_issue: got %b want 10", {issue, stall});
    else n_pass++;
    n_total++;
    if (stall_cnt !== 16'd3) $display("FAIL raw_stall_cnt: got %0d want 3", stall_cnt);
    else n_pass++;
    id_valid = 1'b0;
    cyc();
  endtask

  task automatic test_vec_sep();
    do_reset();
    set_inst(1'b1, 2'b00, 2'b00, 1'b1, 4'd3, 4'd0, 4'd0);
    #1;
    cyc();
    set_inst(1'b1, 2'b00, 2'b00, 1'b0, 4'd4, 4'd3, 4'd3);
    #1;
    n_total++;
    if ({issue, stall} !== 2'b10) $display("FAIL vec_sep: got %b want 10", {issue, stall});
    else n_pass++;
    cyc();
    // Same vector register read next: must stall (vector R3 busy).
    set_inst(1'b1, 2'b00, 2'b00, 1'b1, 4'd6, 4'd3, 4'd0);
    #1;
    n_total++;
    if (stall !== 1'b1) $display("FAIL vec_raw: got stall=%b want 1", stall);
    else n_pass++;
    id_valid = 1'b0;
    cyc();
  endtask

  task automatic test_load_waw();
    do_reset();
    set_inst(1'b1, 2'b01, 2'b00, 1'b0, 4'd5, 4'd0, 4'd0);
    #1;
    cyc();
    set_inst(1'b1, 2'b00, 2'b00, 1'b0, 4'd5, 4'd1, 4'd2);
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++;
      if (stall !== 1'b1) $display("FAIL waw_stall_c%0d: got %b want 1", i, stall);
      else n_pass++;
      cyc();
    end
    #1;
    n_total++;
    if (issue !== 1'b1 || stall_cnt !== 16'd5)
      $display("FAIL waw_issue: got issue=%b cnt=%0d want 1/5", issue, stall_cnt);
    else n_pass++;
    cyc();
    // Store reads R1: stalls on the ALU write just issued to R5.
    set_inst(1'b1, 2'b01, 2'b01, 1'b0, 4'd5, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) cyc();
    #1;
    n_total++;
    if (issue !== 1'b1 || stall_cnt !== 16'd8)
      $display("FAIL store_raw: got issue=%b cnt=%0d want 1/8", issue, stall_cnt);
    else n_pass++;
    id_valid = 1'b0;
    cyc();
  endtask

  task automatic test_nop();
    do_reset();
    set_inst(1'b1, 2'b01, 2'b00, 1'b0, 4'd7, 4'd0, 4'd0);
    #1;
    cyc();
    set_inst(1'b1, 2'b01, 2'b10, 1'b0, 4'd7, 4'd7, 4'd7);
    #1;
    n_total++;
    if (issue !== 1'b1) $display("FAIL nop_01_1x: got issue=%b want 1", issue);
    else n_pass++;
    set_inst(1'b1, 2'b11, 2'b00, 1'b0, 4'd7, 4'd7, 4'd7);
    #1;
    n_total++;
    if (issue !== 1'b1) $display("FAIL nop_11: got issue=%b want 1", issue);
    else n_pass++;
    set_inst(1'b1, 2'b10, 2'b00, 1'b0, 4'd7, 4'd7, 4'd7);
    #1;
    n_total++;
    if (issue !== 1'b1) $display("FAIL jump_op: got issue=%b want 1", issue);
    else n_pass++;
    id_valid = 1'b0;
    cyc();
  endtask

  task automatic test_jump_over_stall();
    logic [2:0] exp_ff [3] = '{1'b1, 1'b1, 1'b1};
    do_reset();
    set_inst(1'b1, 2'b00, 2'b00, 1'b0, 4'd3, 4'd0, 4'd0);
    #1;
    cyc();
    set_inst(1'b1, 2'b00, 2'b00, 1'b0, 4'd4, 4'd3, 4'd0);
    #1;
    n_total++;
    if (stall !== 1'b1) $display("FAIL jmp_pre_stall: got %b want 1", stall);
    else n_pass++;
    cyc();
    ex_jmp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if ({fetch_flush, stall, issue, pc_en} !== {exp_ff[i][0], 3'b001})
        $display("FAIL jmp_flush_c%0d: got %b want 1001", i,
                 {fetch_flush, stall, issue, pc_en});
      else n_pass++;
      cyc();
      ex_jmp = 1'b0;
    end
    #1;
    n_total++;
    if ({fetch_flush, issue} !== 2'b01)
      $display("FAIL jmp_back_to_run: got %b want 01", {fetch_flush, issue});
    else n_pass++;
    n_total++;
    if (stall_cnt !== 16'd1) $display("FAIL jmp_stall_cnt: got %0d want 1", stall_cnt);
    else n_pass++;
    id_valid = 1'b0;
    cyc();
  endtask

  task automatic test_jump_reload();
    do_reset();
    ex_jmp = 1'b1;
    cyc();
    cyc();
    ex_jmp = 1'b0;
    cyc();
    #1;
    n_total++;
    if (fetch_flush !== 1'b1) $display("FAIL reload_extend: got %b want 1", fetch_flush);
    else n_pass++;
    cyc();
    #1;
    n_total++;
    if (fetch_flush !== 1'b0) $display("FAIL reload_exit: got %b want 0", fetch_flush);
    else n_pass++;
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    set_inst(1'b1, 2'b00, 2'b00, 1'b0, 4'd9, 4'd0, 4'd0);
    #1;
    cyc();
    id_valid = 1'b0;
    ex_jmp = 1'b1;
    cyc();
    ex_jmp = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if ({issue, pc_en, fetch_flush} !== 3'b001)
        $display("FAIL rst_flush_c%0d: got %b want 001", i, {issue, pc_en, fetch_flush});
      else n_pass++;
      cyc();
    end
    rst = 1'b0;
    set_inst(1'b1, 2'b00, 2'b00, 1'b0, 4'd1, 4'd9, 4'd0);
    #1;
    n_total++;
    if ({issue, stall, fetch_flush} !== 3'b100)
      $display("FAIL rst_forget: got %b want 100", {issue, stall, fetch_flush});
    else n_pass++;
    id_valid = 1'b0;
    cyc();
  endtask

  task automatic test_saturation();
    do_reset();
    // Self-dependent load: issues once per 6 cycles, stalls the other 5.
    set_inst(1'b1, 2'b01, 2'b00, 1'b0, 4'd5, 4'd5, 4'd0);
    repeat (80000) @(posedge clk);
    #1;
    n_total++;
    if (stall_cnt !== 16'hFFFF) $display("FAIL saturation: got %h want ffff", stall_cnt);
    else n_pass++;
    id_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_vec_sep();
    test_load_waw();
    test_nop();
    test_jump_over_stall();
    test_jump_reload();
    test_reset_mid_flush();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Scoreboard-based pipeline controller for the vector ASIP. Sits beside the fetch/decode pipeline register and, each cycle, decides whether the decoded instruction may issue, must stall, or is flushed. It tracks pending writes to the 16 scalar and 16 vector registers and holds the PC and fetch register on hazards. It also sequences the multi-cycle flush that follows a taken jump from execute.

## Interface

Parameters:
- ALU_LAT, default 3: cycles from issue until an arithmetic result is written back (1..7).
- MEM_LAT, default 5: cycles from issue until load data is written back (1..7).
- FLUSH_CYCLES, default 2: cycles the fetch register is held in flush after a taken jump (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode-stage fields hold a real instruction.
- id_op  in  2  instruction class, bits [31:30].
- id_inst  in  2  sub-opcode, bits [29:28].
- id_flagV  in  1  1 = register fields address the vector file, 0 = scalar file.
- id_r1  in  4  R1/V1 field, bits [3:0].
- id_r2  in  4  R2/V2 field, bits [7:4].
- id_r3  in  4  R3/V3 field, bits [11:8].
- ex_jmp  in  1  execute stage reports a taken jump this cycle.
- issue  out  1  decoded instruction advances to execute this cycle.
- stall  out  1  hold PC and fetch register; insert bubble into execute.
- pc_en  out  1  PC register update enable.
- fetch_flush  out  1  drives the fetch register's clear input.
- stall_cnt  out  16  saturating count of stall cycles since reset.

## Operation

- Register-use decode (decided ISA classes):
  - op=00 arithmetic: writes R1; reads R2, R3; latency ALU_LAT.
  - op=01, inst=00 load: writes R1; reads R2; latency MEM_LAT.
  - op=01, inst=01 store: reads R1, R2; no write.
  - op=10 control/jump: no reads, no writes.
  - op=11, and op=01 with inst=1x: NOP, no reads, no writes.
- Register index is {id_flagV, field}. The scoreboard has 32 entries, each a 3-bit down-counter of cycles until writeback.
- Hazard: id_valid and either of the following. A counter of nonzero means busy.
  - Any read register is busy (RAW).
  - The write register is busy (WAW).
- State machine:
  - RUN:
    - ex_jmp=1 -> FLUSH, with the flush counter loaded to FLUSH_CYCLES-1.
    - Otherwise stay in RUN.
  - FLUSH:
    - The flush counter decrements each cycle; exit to RUN when it reaches 0.
    - ex_jmp=1 while in FLUSH reloads the flush counter.
- Combinational outputs:
  - fetch_flush = ex_jmp | (state==FLUSH).
  - stall = hazard & ~fetch_flush (jump wins; the stalled instruction is discarded).
  - issue = id_valid & ~hazard & ~fetch_flush.
  - pc_en = ~stall.
- Scoreboard update at each clock edge:
  - Every nonzero counter decrements by 1.
  - If issue and the instruction writes, its destination counter loads ALU_LAT or MEM_LAT. The load overrides the decrement; WAW stall guarantees the entry was 0.
- stall_cnt increments on every cycle with stall=1 and saturates at 16'hFFFF.

## Timing

- Reset values:
  - While rst=1: all scoreboard counters 0, state RUN, flush counter 0, stall_cnt 0.
  - Outputs during reset: issue=0, stall=0, pc_en=0, fetch_flush=1 (forced).
- Hazard decision is combinational from the registered scoreboard, with zero-cycle latency from the id_* inputs.
- An instruction issued in cycle t with latency L frees its register in cycle t+L+1. A dependent instruction issues in cycle t+L+1 at the earliest. There is no forwarding.
- Flush timing:
  - Flush begins in the cycle ex_jmp is high.
  - It lasts 1+FLUSH_CYCLES cycles total unless ex_jmp is re-asserted.
- During flush, scoreboard counters keep decrementing, and pc_en=1 so the PC loads the jump target.
- Asynchronous reset mid-flush or mid-stall returns to RUN immediately. All pending writes are forgotten.

## Test plan

- RAW stall: issue op=00 scalar R1=3, then op=00 reading R2=3 with ALU_LAT=3. Required: stall=1 for 3 cycles, the dependent issues in cycle t+4, and stall_cnt=3.
- Vector/scalar separation: issue op=00 with flagV=1 and R1=3, then flagV=0 reading R2=3. Required: no stall, issue=1 the next cycle.
- Load latency plus WAW: issue a load to R1=5, then op=00 writing R1=5. Required: stall for 5 cycles with MEM_LAT=5.
- Jump over stall: during a RAW stall, assert ex_jmp for one cycle. Required:
  - fetch_flush=1 for 3 cycles, stall=0, issue=0.
  - State returns to RUN afterwards.
- Reset mid-flush: assert rst during FLUSH. Required:
  - issue=0, pc_en=0, fetch_flush=1 while rst is high.
  - After release, a previously busy register reads as free immediately.
- Saturation: hold a permanent hazard for 70000 cycles. Required: stall_cnt=16'hFFFF.
